if_axi_fetch_ctrl: RTL and testbench
====================================

// Module: if_axi_fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer between the IF-stage PC and the AXI4 read channel of the instruction memory.
//  Issues one single-beat read per PC value and holds the returned word for the IF/ID register.
//  Stalls the pipeline until the word arrives.
//  Discards responses made stale by a branch/jump redirect.
// PARAMETERS
//  ID_W      4             width of ARID
//  AR_ID     0             constant ARID driven on every request
//  NOP_INST  32'h00000013  instruction word delivered on reset / error (addi x0,x0,0)
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst          in   1   asynchronous, active-low reset
//  pc_addr      in   32  current PC (IM_address) from the PC register
//  pc_valid     in   1   core requests the instruction at pc_addr
//  redirect     in   1   branch|jump taken this cycle; PC changes at the next edge
//  pipe_stall   in   1   IF/ID not written this cycle (hazard stall); hold delivered word
//  ARID         out  ID_W   = AR_ID
//  ARADDR       out  32  read address, registered
//  ARLEN        out  4   = 0 (single beat)
//  ARSIZE       out  3   = 3'b010 (4 bytes)
//  ARBURST      out  2   = 2'b01 (INCR)
//  ARVALID      out  1   address valid
//  ARREADY      in   1   slave accepts address
//  RDATA        in   32  read data
//  RRESP        in   2   read response; 2'b00 = OKAY
//  RVALID       in   1   read data valid
//  RREADY       out  1   master accepts data
//  inst_out     out  32  fetched instruction to IF/ID
//  inst_valid   out  1   inst_out corresponds to the current pc_addr
//  fetch_stall  out  1   freeze PC and IF/ID; combines into PC_write/IF_ID_write
//  fetch_err    out  1   1-cycle pulse: non-OKAY response received
//  stall_cnt    out  32  count of cycles with fetch_stall=1; wraps 0xFFFFFFFF->0
// BEHAVIOUR
//  States: IDLE, ADDR, DATA, HOLD. Reset (rst=0, async):
//   - state=IDLE; ARVALID=0; RREADY=0; ARADDR=0
//   - inst_out=NOP_INST; inst_valid=0; fetch_err=0; kill=0; stall_cnt=0
//  IDLE : pc_valid=1 -> ARADDR<=pc_addr, ->ADDR.
//  ADDR : ARVALID=1. ARADDR/ARVALID stable until ARREADY=1; on handshake ->DATA.
//  DATA : RREADY=1. On RVALID&RREADY:
//   - kill=1 -> drop data, clear kill, ->IDLE.
//   - RRESP!=0 -> inst_out<=NOP_INST, fetch_err pulse, inst_valid<=1, ->HOLD.
//   - else inst_out<=RDATA, inst_valid<=1, ->HOLD.
//  HOLD : inst_valid=1, word held.
//   - redirect=1 -> inst_valid<=0, ->IDLE.
//   - pipe_stall=0 -> inst_valid<=0, ->IDLE.
//   - else stay.
//  Redirect handling:
//   - redirect in ADDR or DATA sets kill. ARVALID is never withdrawn (AXI rule).
//   - redirect in IDLE: no effect; the new PC is fetched normally.
//   - redirect on the same cycle as the R handshake in DATA counts as kill.
//  fetch_stall, combinational: 1 in ADDR and DATA; 1 in IDLE when pc_valid=1; 0 in HOLD.
//  Latency:
//   - IDLE->HOLD minimum 3 cycles (ARREADY and RVALID both already high).
//   - One IDLE bubble per instruction, by design.
//  At most one read outstanding. RREADY=0 outside DATA.
//  stall_cnt += 1 each cycle fetch_stall=1.
//  rst asserted mid-transaction: all state cleared immediately.
//   - The interconnect is reset by the same rst, so no orphan R beat is expected.
// TESTING
//  1. pc_addr=0x0, ARREADY=1, RVALID 1 cycle after AR handshake, RDATA=0x00500093
//     -> ARADDR=0x0, ARVALID 1 cycle; inst_out=0x00500093, inst_valid=1, fetch_stall low in HOLD.
//  2. ARREADY held 0 for 5 cycles
//     -> ARVALID and ARADDR stable all 5 cycles; fetch_stall=1; stall_cnt increments by 5 plus base.
//  3. redirect pulse in DATA, then RDATA=0xDEADBEEF
//     -> word dropped, inst_valid stays 0, new ARADDR=branch target issued.
//  4. pipe_stall=1 for 3 cycles in HOLD
//     -> inst_out constant 3 cycles, no new ARVALID; then IDLE and the next fetch.
//  5. RRESP=2'b10 -> inst_out=0x00000013, fetch_err high exactly 1 cycle, inst_valid=1.
//  6. rst=0 asserted while in DATA -> outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/if_axi_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_axi_fetch_ctrl
// Instruction-fetch sequencer between the IF-stage PC and the AXI4 read
// channel of the instruction memory. One single-beat read is issued per PC
// value. The returned word is held for the IF/ID register, and the pipeline
// is stalled until that word arrives. A response made stale by a branch or
// jump redirect is discarded.
//
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   pc_addr/pc_valid  : PC to fetch, with its request strobe
//   redirect          : branch/jump taken this cycle
//   pipe_stall        : IF/ID is held by a hazard stall
//   AR* / R*          : AXI4 read address and read data channels (master side)
//   inst_out/valid    : fetched word for IF/ID, and its valid flag
//   fetch_stall       : freezes the PC and IF/ID while a fetch is in flight
//   fetch_err         : 1-cycle pulse when a non-OKAY response is received
//   stall_cnt         : free-running count of stalled cycles (wraps to 0)
// ---------------------------------------------------------------------------
module if_axi_fetch_ctrl #(
  parameter int              ID_W     = 4,
  parameter logic [ID_W-1:0] AR_ID    = {ID_W{1'b0}},
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     pc_addr,
  input  logic            pc_valid,
  input  logic            redirect,
  input  logic            pipe_stall,
  output logic [ID_W-1:0] ARID,
  output logic [31:0]     ARADDR,
  output logic [3:0]      ARLEN,
  output logic [2:0]      ARSIZE,
  output logic [1:0]      ARBURST,
  output logic            ARVALID,
  input  logic            ARREADY,
  input  logic [31:0]     RDATA,
  input  logic [1:0]      RRESP,
  input  logic            RVALID,
  output logic            RREADY,
  output logic [31:0]     inst_out,
  output logic            inst_valid,
  output logic            fetch_stall,
  output logic            fetch_err,
  output logic [31:0]     stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_araddr;
  logic        r_arvalid;
  logic        r_rready;
  logic [31:0] r_inst;
  logic        r_inst_valid;
  logic        r_fetch_err;
  logic        r_kill;
  logic [31:0] r_stall_cnt;
  logic        w_kill_nxt;
  logic        w_fetch_stall;
  logic        w_r_hs;
  logic        w_drop;

  // An AXI read response is accepted only when it is OKAY.
  function automatic logic resp_ok(input logic [1:0] resp);
    return (resp == 2'b00);
  endfunction

  // RREADY is high only in DATA, so the handshake implies the DATA state.
  assign w_r_hs = RVALID && r_rready;
  // A redirect that coincides with the handshake also makes the beat stale.
  assign w_drop = r_kill || redirect;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (pc_valid) w_state_nxt = S_ADDR;
        else          w_state_nxt = S_IDLE;
      end
      S_ADDR: begin
        if (ARREADY) w_state_nxt = S_DATA;
        else         w_state_nxt = S_ADDR;
      end
      S_DATA: begin
        if (w_r_hs) begin
          if (w_drop) w_state_nxt = S_IDLE;
          else        w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_HOLD: begin
        if (redirect || !pipe_stall) w_state_nxt = S_IDLE;
        else                         w_state_nxt = S_HOLD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: combinational stall and the kill flag update.
  always_comb begin
    w_fetch_stall = 1'b0;
    w_kill_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_fetch_stall = pc_valid;
        w_kill_nxt    = 1'b0;
      end
      S_ADDR: begin
        // ARVALID cannot be withdrawn, so a redirect is only remembered here.
        w_fetch_stall = 1'b1;
        w_kill_nxt    = r_kill || redirect;
      end
      S_DATA: begin
        w_fetch_stall = 1'b1;
        if (w_r_hs) w_kill_nxt = 1'b0;
        else        w_kill_nxt = r_kill || redirect;
      end
      S_HOLD: begin
        w_fetch_stall = 1'b0;
        w_kill_nxt    = 1'b0;
      end
      default: begin
        w_fetch_stall = 1'b0;
        w_kill_nxt    = 1'b0;
      end
    endcase
  end

  // AXI request/response registers, delivered word and stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_araddr     <= 32'h0000_0000;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_inst       <= NOP_INST;
      r_inst_valid <= 1'b0;
      r_fetch_err  <= 1'b0;
      r_kill       <= 1'b0;
      r_stall_cnt  <= 32'h0000_0000;
    end else begin
      r_fetch_err <= 1'b0;
      r_kill      <= w_kill_nxt;
      r_stall_cnt <= r_stall_cnt + {31'd0, w_fetch_stall};
      case (r_state)
        S_IDLE: begin
          if (pc_valid) begin
            r_araddr  <= pc_addr;
            r_arvalid <= 1'b1;
          end
        end
        S_ADDR: begin
          if (ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        S_DATA: begin
          if (w_r_hs) begin
            r_rready <= 1'b0;
            if (!w_drop) begin
              r_inst_valid <= 1'b1;
              if (resp_ok(RRESP)) begin
                r_inst <= RDATA;
              end else begin
                r_inst      <= NOP_INST;
                r_fetch_err <= 1'b1;
              end
            end
          end
        end
        S_HOLD: begin
          if (w_state_nxt == S_IDLE) r_inst_valid <= 1'b0;
        end
        default: begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b0;
        end
      endcase
    end
  end

  assign ARID        = AR_ID;
  assign ARADDR      = r_araddr;
  assign ARLEN       = 4'd0;
  assign ARSIZE      = 3'b010;
  assign ARBURST     = 2'b01;
  assign ARVALID     = r_arvalid;
  assign RREADY      = r_rready;
  assign inst_out    = r_inst;
  assign inst_valid  = r_inst_valid;
  assign fetch_stall = w_fetch_stall;
  assign fetch_err   = r_fetch_err;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_if_axi_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_axi_fetch_ctrl
// Self-checking bench for if_axi_fetch_ctrl. A table of fetch transactions
// is played against a scripted AXI slave. The expected delivered word is
// queued when the read beat is driven and is compared when inst_valid rises.
// Hand-written sequences cover redirect kills and mid-transaction reset.
// ---------------------------------------------------------------------------
module tb_if_axi_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_valid;
  logic        redirect;
  logic        pipe_stall;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] inst_out;
  logic        inst_valid;
  logic        fetch_stall;
  logic        fetch_err;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  if_axi_fetch_ctrl #(.ID_W(4), .AR_ID(4'd0), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_valid(pc_valid),
    .redirect(redirect), .pipe_stall(pipe_stall),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .inst_out(inst_out), .inst_valid(inst_valid), .fetch_stall(fetch_stall),
    .fetch_err(fetch_err), .stall_cnt(stall_cnt)
  );

  int checks   = 0;
  int failures = 0;
  int exp_stall = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          ar_wait;
    int          r_wait;
    int          hold;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each rising inst_valid must match the oldest queued word.
  logic prev_iv = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst && inst_valid && !prev_iv) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got inst %h with nothing expected at %0t", inst_out, $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_inst", inst_out, e.inst);
        chk("sb_err", {31'd0, fetch_err}, {31'd0, e.err});
      end
    end
    prev_iv = inst_valid;
  end

  // One full fetch; starts and ends one time unit after a rising edge, in IDLE.
  task automatic do_fetch(input vec_t v);
    pc_addr  = v.addr;
    pc_valid = 1'b1;
    #1 chk("stall_idle_req", {31'd0, fetch_stall}, 32'd1);
    @(posedge clk); #1;
    pc_valid = 1'b0;
    chk("arvalid_up", {31'd0, ARVALID}, 32'd1);
    chk("araddr", ARADDR, v.addr);
    for (int k = 0; k < v.ar_wait; k++) begin
      chk("ar_wait_stall", {31'd0, fetch_stall}, 32'd1);
      @(posedge clk); #1;
      chk("arvalid_hold", {31'd0, ARVALID}, 32'd1);
      chk("araddr_hold", ARADDR, v.addr);
    end
    ARREADY = 1'b1;
    @(posedge clk); #1;
    ARREADY = 1'b0;
    chk("arvalid_drop", {31'd0, ARVALID}, 32'd0);
    chk("rready_up", {31'd0, RREADY}, 32'd1);
    for (int k = 0; k < v.r_wait; k++) begin
      @(posedge clk); #1;
    end
    RDATA      = v.rdata;
    RRESP      = v.rresp;
    RVALID     = 1'b1;
    pipe_stall = (v.hold != 0);
    exp_q.push_back('{v.exp_inst, v.exp_err});
    @(posedge clk); #1;
    RVALID = 1'b0;
    exp_stall += 3 + v.ar_wait + v.r_wait;
    chk("rready_drop", {31'd0, RREADY}, 32'd0);
    chk("hold_no_stall", {31'd0, fetch_stall}, 32'd0);
    chk("hold_valid", {31'd0, inst_valid}, 32'd1);
    for (int k = 0; k < v.hold; k++) begin
      chk("hold_inst", inst_out, v.exp_inst);
      chk("hold_no_ar", {31'd0, ARVALID}, 32'd0);
      @(posedge clk); #1;
      chk("err_one_cycle", {31'd0, fetch_err}, 32'd0);
    end
    pipe_stall = 1'b0;
    @(posedge clk); #1;
    chk("valid_drop", {31'd0, inst_valid}, 32'd0);
    chk("err_low", {31'd0, fetch_err}, 32'd0);
    chk("stall_cnt", stall_cnt, exp_stall);
  endtask

  // Fetch killed by a redirect: mode 0 in ADDR, 1 in DATA, 2 on the R handshake.
  task automatic do_killed(input logic [31:0] addr, input int mode);
    pc_addr  = addr;
    pc_valid = 1'b1;
    @(posedge clk); #1;
    pc_valid = 1'b0;
    if (mode == 0) begin
      redirect = 1'b1;
      @(posedge clk); #1;
      redirect = 1'b0;
      chk("kill_arvalid_kept", {31'd0, ARVALID}, 32'd1);
      chk("kill_araddr_kept", ARADDR, addr);
    end
    ARREADY = 1'b1;
    @(posedge clk); #1;
    ARREADY = 1'b0;
    if (mode == 1) begin
      redirect = 1'b1;
      @(posedge clk); #1;
      redirect = 1'b0;
    end
    RDATA  = 32'hDEAD_BEEF;
    RRESP  = 2'b00;
    RVALID = 1'b1;
    if (mode == 2) redirect = 1'b1;
    @(posedge clk); #1;
    RVALID   = 1'b0;
    redirect = 1'b0;
    exp_stall += (mode == 2) ? 3 : 4;
    chk("kill_valid_low", {31'd0, inst_valid}, 32'd0);
    chk("kill_rready_low", {31'd0, RREADY}, 32'd0);
    chk("kill_idle_no_ar", {31'd0, ARVALID}, 32'd0);
    chk("kill_stall_cnt", stall_cnt, exp_stall);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tgt;
    vecs[0] = '{32'h0000_0000, 32'h0050_0093, 2'b00, 0, 0, 0, 32'h0050_0093, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h00A0_0113, 2'b00, 5, 0, 0, 32'h00A0_0113, 1'b0};
    vecs[2] = '{32'h0000_0008, 32'h0020_81B3, 2'b00, 0, 2, 3, 32'h0020_81B3, 1'b0};
    vecs[3] = '{32'h0000_000C, 32'hCAFE_F00D, 2'b10, 0, 1, 2, NOP,           1'b1};
    vecs[4] = '{32'h0000_0010, 32'h1234_5678, 2'b11, 1, 0, 0, NOP,           1'b1};
    vecs[5] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 2'b01, 0, 0, 0, NOP,           1'b1};

    rst = 1'b0; pc_addr = 32'd0; pc_valid = 1'b0; redirect = 1'b0;
    pipe_stall = 1'b0; ARREADY = 1'b0; RDATA = 32'd0; RRESP = 2'b00; RVALID = 1'b0;
    #12;
    chk("rst_arvalid", {31'd0, ARVALID}, 32'd0);
    chk("rst_rready", {31'd0, RREADY}, 32'd0);
    chk("rst_araddr", ARADDR, 32'd0);
    chk("rst_inst", inst_out, NOP);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("const_ar", {ARID, ARLEN, ARSIZE, ARBURST, 19'd0}, {4'd0, 4'd0, 3'b010, 2'b01, 19'd0});
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      do_fetch(vecs[i]);
    end

    for (int m = 0; m < 3; m++) begin
      do_killed(32'h0000_0100 + 32'(m * 16), m);
      tgt = '{32'h0000_0200 + 32'(m * 16), 32'h0000_0517 + 32'(m), 2'b00, 0, 0, 0,
              32'h0000_0517 + 32'(m), 1'b0};
      do_fetch(tgt);
    end

    // Reset while a read is in DATA clears everything without a clock edge.
    pc_addr  = 32'h0000_0040;
    pc_valid = 1'b1;
    @(posedge clk); #1;
    pc_valid = 1'b0;
    ARREADY  = 1'b1;
    @(posedge clk); #1;
    ARREADY  = 1'b0;
    chk("pre_rst_rready", {31'd0, RREADY}, 32'd1);
    #2 rst = 1'b0;
    #1;
    exp_stall = 0;
    chk("arst_rready", {31'd0, RREADY}, 32'd0);
    chk("arst_arvalid", {31'd0, ARVALID}, 32'd0);
    chk("arst_araddr", ARADDR, 32'd0);
    chk("arst_inst", inst_out, NOP);
    chk("arst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst_stall_cnt", stall_cnt, 32'd0);
    chk("arst_fetch_stall", {31'd0, fetch_stall}, 32'd0);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    do_fetch(vecs[0]);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
